// File: rtl/alu_op_arbiter_if.sv
// Request/grant bundle between ALU requesters and the op-select arbiter.
interface alu_op_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [3*N_REQ-1:0] opcode_i;
  logic [N_REQ-1:0]   grant;
  logic [2:0]         opsel;
  logic               alu_start;
  logic               busy;
  logic               done;
  logic [ID_W-1:0]    done_id;

  // Requester side: raises requests and consumes grants/results.
  modport master (
    output req, opcode_i,
    input  grant, opsel, alu_start, busy, done, done_id
  );

  // Arbiter side.
  modport slave (
    input  req, opcode_i,
    output grant, opsel, alu_start, busy, done, done_id
  );
endinterface

// File: rtl/alu_op_arbiter.sv
// Round-robin arbiter that hands one shared 8-to-1 ALU op mux to one of
// N_REQ requesters at a time and holds the selected op for LAT cycles.
module alu_op_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LAT   = 2
) (
  input logic             clk,
  input logic             rst_n,
  alu_op_arbiter_if.slave bus
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [N_REQ-1:0] grant_q;
  logic [2:0]       opsel_q;
  logic             start_q;
  logic             busy_q;
  logic             done_q;
  logic [ID_W-1:0]  done_id_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [3:0]       cnt_q;

  logic             found_d;
  logic [ID_W-1:0]  win_d;
  logic [N_REQ-1:0] onehot_d;
  logic [2:0]       op_d;
  logic [ID_W-1:0]  rr_next_d;
  int unsigned      idx;

  // Pick the first requesting index at or above rr_ptr, wrapping to 0.
  always_comb begin
    found_d  = 1'b0;
    win_d    = '0;
    idx      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found_d && bus.req[idx]) begin
        found_d = 1'b1;
        win_d   = ID_W'(idx);
      end
    end
    onehot_d        = '0;
    onehot_d[win_d] = 1'b1;
    op_d            = bus.opcode_i[3*win_d +: 3];
    rr_next_d       = (done_id_q == ID_W'(N_REQ - 1)) ? '0 : done_id_q + ID_W'(1);
  end

  // Control FSM; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      opsel_q   <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      grant_q <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            state_q   <= S_EXEC;
            grant_q   <= onehot_d;
            opsel_q   <= op_d;
            start_q   <= 1'b1;
            done_id_q <= win_d;
            cnt_q     <= 4'(LAT - 1);
            busy_q    <= 1'b1;
          end
        end
        S_EXEC: begin
          if (cnt_q == '0) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            rr_ptr_q <= rr_next_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.opsel     = opsel_q;
  assign bus.alu_start = start_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Directed bench for alu_op_arbiter with N_REQ=4, LAT=2.
module tb_alu_op_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_op_arbiter_if #(.N_REQ(4)) bus ();

  alu_op_arbiter #(.N_REQ(4), .LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.opcode_i = '0;
    step();
    total++;
    if ({bus.grant, bus.opsel, bus.alu_start, bus.busy, bus.done, bus.done_id} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=000",
               {bus.grant, bus.opsel, bus.alu_start, bus.busy, bus.done, bus.done_id});
    end
    rst_n = 1'b1;
    step();
    total++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_req grant=%b busy=%b exp 0000/0", bus.grant, bus.busy);
    end
  endtask

  task automatic test_single();
    bus.req      = 4'b0010;
    bus.opcode_i = 12'b000_000_011_000;
    step();
    total++;
    if (bus.grant !== 4'b0010 || bus.opsel !== 3'b011 || bus.alu_start !== 1'b1 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant grant=%b opsel=%b start=%b busy=%b exp 0010/011/1/1",
               bus.grant, bus.opsel, bus.alu_start, bus.busy);
    end
    bus.req = 4'b0000;
    step();
    total++;
    if (bus.grant !== 4'b0000 || bus.alu_start !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL single_exec2 grant=%b start=%b busy=%b done=%b exp 0000/0/1/0",
               bus.grant, bus.alu_start, bus.busy, bus.done);
    end
    step();
    total++;
    if (bus.done !== 1'b1 || bus.done_id !== 2'd1 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL single_done done=%b id=%0d busy=%b exp 1/1/1", bus.done, bus.done_id, bus.busy);
    end
    step();
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.opsel !== 3'b011) begin
      bad++;
      $display("FAIL single_idle done=%b busy=%b opsel=%b exp 0/0/011", bus.done, bus.busy, bus.opsel);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    logic [2:0] exp_o [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_o = '{3'b000, 3'b001, 3'b010, 3'b111, 3'b000};
    rst_n = 1'b0;
    step();
    rst_n        = 1'b1;
    bus.opcode_i = 12'b111_010_001_000;
    bus.req      = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (bus.grant !== exp_g[i] || bus.opsel !== exp_o[i]) begin
        bad++;
        $display("FAIL rr_grant%0d grant=%b opsel=%b exp %b/%b", i, bus.grant, bus.opsel, exp_g[i], exp_o[i]);
      end
      if (i == 4) bus.req = 4'b0000;
      for (int j = 0; j < 3; j++) begin
        step();
        total++;
        if (bus.grant !== 4'b0000) begin
          bad++;
          $display("FAIL rr_gap%0d_%0d grant=%b exp 0000", i, j, bus.grant);
        end
      end
    end
  endtask

  task automatic test_wrap();
    bus.req = 4'b0100;
    step();
    total++;
    if (bus.grant !== 4'b0100) begin
      bad++;
      $display("FAIL wrap_serve2 grant=%b exp 0100", bus.grant);
    end
    bus.req = 4'b0000;
    step(); step(); step();
    bus.req = 4'b1001;
    step();
    total++;
    if (bus.grant !== 4'b1000) begin
      bad++;
      $display("FAIL wrap_first grant=%b exp 1000", bus.grant);
    end
    bus.req = 4'b0001;
    step(); step(); step(); step();
    total++;
    if (bus.grant !== 4'b0001) begin
      bad++;
      $display("FAIL wrap_second grant=%b exp 0001", bus.grant);
    end
    bus.req = 4'b0000;
    step(); step(); step();
  endtask

  task automatic test_midop();
    bus.opcode_i = 12'b000_011_000_101;
    bus.req      = 4'b0001;
    step();
    total++;
    if (bus.grant !== 4'b0001 || bus.opsel !== 3'b101) begin
      bad++;
      $display("FAIL midop_grant grant=%b opsel=%b exp 0001/101", bus.grant, bus.opsel);
    end
    bus.opcode_i = 12'b000_011_000_110;
    bus.req      = 4'b0100;
    step();
    step();
    total++;
    if (bus.done !== 1'b1 || bus.done_id !== 2'd0 || bus.opsel !== 3'b101) begin
      bad++;
      $display("FAIL midop_done done=%b id=%0d opsel=%b exp 1/0/101", bus.done, bus.done_id, bus.opsel);
    end
    step();
    step();
    total++;
    if (bus.grant !== 4'b0100 || bus.opsel !== 3'b011) begin
      bad++;
      $display("FAIL midop_next grant=%b opsel=%b exp 0100/011", bus.grant, bus.opsel);
    end
    bus.req = 4'b0000;
    step(); step(); step();
  endtask

  task automatic test_reset_mid();
    int seen_done;
    seen_done = 0;
    bus.req   = 4'b0001;
    step();
    bus.req = 4'b0000;
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.grant, bus.opsel, bus.alu_start, bus.busy, bus.done, bus.done_id} !== 12'h000) begin
      bad++;
      $display("FAIL rstmid_outputs got=%h exp=000",
               {bus.grant, bus.opsel, bus.alu_start, bus.busy, bus.done, bus.done_id});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      if (bus.done === 1'b1) seen_done++;
    end
    rst_n   = 1'b1;
    bus.req = 4'b0100;
    step();
    total++;
    if (bus.grant !== 4'b0100 || seen_done != 0) begin
      bad++;
      $display("FAIL rstmid_regrant grant=%b done_pulses=%0d exp 0100/0", bus.grant, seen_done);
    end
    bus.req = 4'b0000;
    step(); step();
    total++;
    if (bus.done !== 1'b1 || bus.done_id !== 2'd2) begin
      bad++;
      $display("FAIL rstmid_done done=%b id=%0d exp 1/2", bus.done, bus.done_id);
    end
    step();
  endtask

  task automatic test_pulse();
    bus.req = 4'b0001;
    step();
    bus.req = 4'b0010;
    step();
    bus.req = 4'b0000;
    step();
    step();
    step();
    total++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL pulse_ignored grant=%b busy=%b exp 0000/0", bus.grant, bus.busy);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_midop();
    test_reset_mid();
    test_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_arbiter.md
ALU_OP_ARBITER -- requirements
Module: alu_op_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, the number of requesters sharing the 8-to-1 ALU operation mux (2..8).
REQ-002 The block SHALL have parameter LAT, default 2, the number of cycles the selected ALU operation is held before completion (1..15).
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port req, input, N_REQ: bit i high = requester i wants one ALU operation.
REQ-006 Port opcode_i, input, 3*N_REQ: bits [3i+2:3i] = requested 3-bit opsel of requester i.
REQ-007 Port grant, output, N_REQ: one-hot, one-cycle pulse naming the accepted requester.
REQ-008 Port opsel, output, 3: registered select driven to the ALU 8-to-1 result mux.
REQ-009 Port alu_start, output, 1: one-cycle pulse in the first cycle a new opsel is applied.
REQ-010 Port busy, output, 1: high while an operation is in progress (EXEC or DONE).
REQ-011 Port done, output, 1: one-cycle pulse marking the ALU result valid for the granted requester.
REQ-012 Port done_id, output, $clog2(N_REQ): index of the requester served; valid when done=1.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, EXEC, DONE.
REQ-014 In IDLE with req==0 the block SHALL remain in IDLE with grant, alu_start, done all 0.
REQ-015 In IDLE with req!=0 the winner SHALL be the first set req bit at or after rr_ptr, searching upward and wrapping from N_REQ-1 to 0.
REQ-016 On the edge leaving IDLE the block SHALL enter EXEC, register grant=onehot(winner), opsel=opcode_i[winner], alu_start=1, latch winner into done_id, and load cycle counter with LAT-1.
REQ-017 grant and alu_start SHALL be high for exactly the first EXEC cycle only.
REQ-018 The block SHALL stay in EXEC for exactly LAT cycles, decrementing the counter each cycle and moving to DONE on the edge where counter==0.
REQ-019 In DONE the block SHALL drive done=1 for exactly one cycle, set rr_ptr=(winner+1) mod N_REQ, and return to IDLE on the next edge.
REQ-020 Latency: grant pulse to done pulse SHALL be exactly LAT cycles; back-to-back throughput SHALL be one operation per LAT+2 cycles.
REQ-021 req and opcode_i SHALL be sampled only in IDLE; changes during EXEC/DONE SHALL have no effect on the current operation.
REQ-022 A requester SHALL hold req high until its grant; a req dropped before grant SHALL be ignored and not queued.
REQ-023 opsel SHALL hold its last value through DONE and IDLE until the next grant (no change without alu_start).
REQ-024 done_id SHALL hold its last value outside DONE.
REQ-025 Simultaneous requests SHALL be served in round-robin order; no requester holding req continuously SHALL wait more than N_REQ-1 other operations.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, grant=0, opsel=3'b000, alu_start=0, busy=0, done=0, done_id=0, rr_ptr=0, counter=0.
REQ-027 Reset asserted mid-EXEC or in DONE SHALL abort the operation with no done pulse, both during and after reset.
REQ-028 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge with rst_n high.

Verification
REQ-029 N_REQ=4, LAT=2; req=0010, opcode_i[5:3]=3'b011 -> next edge grant=0010, opsel=011, alu_start=1; done=1, done_id=1 two cycles after grant; busy high 3 cycles.
REQ-030 req=1111 held, opcodes 000/001/010/111 -> grants 0001,0010,0100,1000,0001 in order, each 4 cycles apart, opsel tracking 000,001,010,111,000.
REQ-031 Wrap: rr_ptr=3 after serving 2, req=1001 -> grant=1000 first, then 0001.
REQ-032 Mid-op change: after grant to requester 0, change opcode_i[2:0] and raise req[2] -> opsel unchanged until done; requester 2 granted in next IDLE.
REQ-033 rst_n pulled low in second EXEC cycle -> all outputs 0 immediately, no done pulse; after release, req=0100 -> grant=0100 on first edge.
REQ-034 req pulse of one cycle arriving during EXEC -> never granted; block returns to IDLE with grant=0.
